// File: rtl/sofm_pkg.sv
// Shared types and constants for the SOFM BMU search controller and its compare unit.
package sofm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] DC_STATE_WX = 2'd3;

    localparam int DIS_W_DEF = 26;
    localparam logic [DIS_W_DEF-1:0] DIS_MAX = '1;

    // Index widths never drop below one bit, even for a single neuron or element.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/bmu_search_ctrl_min_tracker.sv
// Running-minimum compare/update unit for the BMU search.
// Optional runner-up tracking is enabled by defining SOFM_RUNNER_UP_EN.
module min_tracker
    import sofm_pkg::*;
#(
    parameter int DIS_W = DIS_W_DEF,
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [DIS_W-1:0] i_dis,
    input  logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] o_best_idx,
    output logic [DIS_W-1:0] o_best_dis,
    output logic [IDX_W-1:0] o_ru_idx,
    output logic [DIS_W-1:0] o_ru_dis
);

    localparam logic [DIS_W-1:0] L_DIS_MAX = '1;

    logic [DIS_W-1:0] r_best_dis;
    logic [IDX_W-1:0] r_best_idx;
    logic             w_new_best;

    // Strict less-than: neurons arrive in ascending order, so ties keep the lower index.
    assign w_new_best = i_en && (i_dis < r_best_dis);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_best_dis <= L_DIS_MAX;
            r_best_idx <= '0;
        end else if (w_new_best) begin
            r_best_dis <= i_dis;
            r_best_idx <= i_idx;
        end
    end

    assign o_best_idx = r_best_idx;
    assign o_best_dis = r_best_dis;

`ifdef SOFM_RUNNER_UP_EN
    logic [DIS_W-1:0] r_ru_dis;
    logic [IDX_W-1:0] r_ru_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_ru_dis <= L_DIS_MAX;
            r_ru_idx <= '0;
        end else if (w_new_best) begin
            r_ru_dis <= r_best_dis;
            r_ru_idx <= r_best_idx;
        end else if (i_en && (i_dis < r_ru_dis)) begin
            r_ru_dis <= i_dis;
            r_ru_idx <= i_idx;
        end
    end

    assign o_ru_idx = r_ru_idx;
    assign o_ru_dis = r_ru_dis;
`else
    assign o_ru_idx = '0;
    assign o_ru_dis = L_DIS_MAX;
`endif

endmodule

// File: rtl/bmu_search_ctrl.sv
// BMU search sequencer: issues {neuron, k} reads, drives the distance accumulator
// and tracks the minimum. Runner-up outputs are live when SOFM_RUNNER_UP_EN is defined.
module bmu_search_ctrl
    import sofm_pkg::*;
#(
    parameter int N_NEURON = 64,
    parameter int DIM      = 16,
    parameter int DIS_W    = DIS_W_DEF,
    parameter int IDX_W    = clog2_min1(N_NEURON),
    parameter int K_W      = clog2_min1(DIM)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [IDX_W+K_W-1:0] o_w_addr,
    output logic [K_W-1:0]       o_x_addr,
    output logic                 o_dc_valid,
    output logic                 o_dc_r,
    output logic [1:0]           o_dc_state,
    input  logic [DIS_W-1:0]     i_dis,
    output logic [IDX_W-1:0]     o_bmu_idx,
    output logic [DIS_W-1:0]     o_bmu_dis,
    output logic [IDX_W-1:0]     o_ru_idx,
    output logic [DIS_W-1:0]     o_ru_dis
);

    state_t           r_state;
    logic [IDX_W-1:0] r_n;
    logic [K_W-1:0]   r_k;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_dc_state;

    logic             w_k_last;
    logic             w_n_last;
    logic             w_start_acc;
    logic             w_vld_p0;
    logic             w_first_p0;
    logic             w_last_p0;
    logic             w_fin_p0;

    logic             r_vld_p1;
    logic             r_first_p1;
    logic             r_last_p1;
    logic             r_fin_p1;
    logic [IDX_W-1:0] r_n_p1;

    logic             r_cmp_p2;
    logic             r_fin_p2;
    logic [IDX_W-1:0] r_n_p2;

    assign w_k_last    = (r_k == K_W'(DIM - 1));
    assign w_n_last    = (r_n == IDX_W'(N_NEURON - 1));
    assign w_start_acc = (r_state == ST_IDLE) && i_start;

    // Stage 1: address issue flags derived from the live counters.
    assign w_vld_p0   = (r_state == ST_ISSUE);
    assign w_first_p0 = w_vld_p0 && (r_k == '0);
    assign w_last_p0  = w_vld_p0 && w_k_last;
    assign w_fin_p0   = w_last_p0 && w_n_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dc_state <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state    <= ST_ISSUE;
                        r_n        <= '0;
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_dc_state <= DC_STATE_WX;
                    end
                end
                ST_ISSUE: begin
                    if (w_k_last) begin
                        r_k <= '0;
                        if (w_n_last) begin
                            r_n     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_n <= r_n + IDX_W'(1);
                        end
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The final neuron is compared this cycle; its result lands with o_done.
                    if (r_fin_p2) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_dc_state <= 2'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stage 2: element-valid / restart presented to the accumulator with the read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
            r_fin_p1   <= 1'b0;
        end else begin
            r_vld_p1   <= w_vld_p0;
            r_first_p1 <= w_first_p0;
            r_last_p1  <= w_last_p0;
            r_fin_p1   <= w_fin_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        r_n_p1 <= r_n;
        r_n_p2 <= r_n_p1;
    end

    // Stage 3: accumulator output holds a complete neuron sum when r_cmp_p2 is set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmp_p2 <= 1'b0;
            r_fin_p2 <= 1'b0;
        end else begin
            r_cmp_p2 <= r_vld_p1 && r_last_p1;
            r_fin_p2 <= r_fin_p1;
        end
    end

    min_tracker #(
        .DIS_W (DIS_W),
        .IDX_W (IDX_W)
    ) u_min_tracker (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_start_acc),
        .i_en       (r_cmp_p2),
        .i_dis      (i_dis),
        .i_idx      (r_n_p2),
        .o_best_idx (o_bmu_idx),
        .o_best_dis (o_bmu_dis),
        .o_ru_idx   (o_ru_idx),
        .o_ru_dis   (o_ru_dis)
    );

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_w_addr   = {r_n, r_k};
    assign o_x_addr   = r_k;
    assign o_dc_valid = r_vld_p1;
    assign o_dc_r     = r_first_p1;
    assign o_dc_state = r_dc_state;

endmodule

// File: tb/tb_bmu_search_ctrl.sv
// Directed bench for bmu_search_ctrl: three instances (4x2, 2x3, 1x1) with a
// behavioural weight memory + accumulator feeding i_dis on the 4x2 instance.
module tb_bmu_search_ctrl;
    import sofm_pkg::*;

    localparam int DW = 26;
    localparam logic [DW-1:0] ONES = DIS_MAX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance A: N=4, DIM=2 -> IDX_W=2, K_W=1
    logic          a_busy, a_done, a_dc_valid, a_dc_r;
    logic [2:0]    a_w_addr;
    logic [0:0]    a_x_addr;
    logic [1:0]    a_dc_state, a_bmu_idx, a_ru_idx;
    logic [DW-1:0] a_dis, a_bmu_dis, a_ru_dis;

    // Instance B: N=2, DIM=3 -> IDX_W=1, K_W=2
    logic          b_busy, b_done, b_dc_valid, b_dc_r;
    logic [2:0]    b_w_addr;
    logic [1:0]    b_x_addr, b_dc_state;
    logic [0:0]    b_bmu_idx, b_ru_idx;
    logic [DW-1:0] b_dis, b_bmu_dis, b_ru_dis;

    // Instance C: N=1, DIM=1 -> IDX_W=1, K_W=1
    logic          c_busy, c_done, c_dc_valid, c_dc_r;
    logic [1:0]    c_w_addr, c_dc_state;
    logic [0:0]    c_x_addr, c_bmu_idx, c_ru_idx;
    logic [DW-1:0] c_dis, c_bmu_dis, c_ru_dis;

    bmu_search_ctrl #(.N_NEURON(4), .DIM(2), .DIS_W(DW)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(st_a), .o_busy(a_busy), .o_done(a_done),
        .o_w_addr(a_w_addr), .o_x_addr(a_x_addr), .o_dc_valid(a_dc_valid), .o_dc_r(a_dc_r),
        .o_dc_state(a_dc_state), .i_dis(a_dis), .o_bmu_idx(a_bmu_idx), .o_bmu_dis(a_bmu_dis),
        .o_ru_idx(a_ru_idx), .o_ru_dis(a_ru_dis));

    bmu_search_ctrl #(.N_NEURON(2), .DIM(3), .DIS_W(DW)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(st_b), .o_busy(b_busy), .o_done(b_done),
        .o_w_addr(b_w_addr), .o_x_addr(b_x_addr), .o_dc_valid(b_dc_valid), .o_dc_r(b_dc_r),
        .o_dc_state(b_dc_state), .i_dis(b_dis), .o_bmu_idx(b_bmu_idx), .o_bmu_dis(b_bmu_dis),
        .o_ru_idx(b_ru_idx), .o_ru_dis(b_ru_dis));

    bmu_search_ctrl #(.N_NEURON(1), .DIM(1), .DIS_W(DW)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_start(st_c), .o_busy(c_busy), .o_done(c_done),
        .o_w_addr(c_w_addr), .o_x_addr(c_x_addr), .o_dc_valid(c_dc_valid), .o_dc_r(c_dc_r),
        .o_dc_state(c_dc_state), .i_dis(c_dis), .o_bmu_idx(c_bmu_idx), .o_bmu_dis(c_bmu_dis),
        .o_ru_idx(c_ru_idx), .o_ru_dis(c_ru_dis));

    // Weight memory (1-cycle read) and accumulator model for instance A.
    logic [DW-1:0] mem_a [8];
    logic [DW-1:0] rd_a  = '0;
    logic [DW-1:0] acc_a = '0;

    always @(posedge clk) begin
        rd_a <= mem_a[a_w_addr];
        if (a_dc_valid)
            acc_a <= (a_dc_r ? '0 : acc_a) + rd_a;
    end
    assign a_dis = acc_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0: st_a = v;
            1: st_b = v;
            default: st_c = v;
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return a_done;
            1: return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0: return a_busy;
            1: return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [1:0] get_dcs(input int which);
        case (which)
            0: return a_dc_state;
            1: return b_dc_state;
            default: return c_dc_state;
        endcase
    endfunction

    // Start in the current cycle (cyc 0); return the cycle o_done was seen (200 = timeout).
    task automatic run(input int which, input int extra_at, output int cyc,
                       output logic busy1, output logic [1:0] dcs1);
        logic got;
        got = 1'b0;
        cyc = 0;
        busy1 = 1'b0;
        dcs1 = 2'd0;
        set_start(which, 1'b1);
        while (!got && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            set_start(which, cyc == extra_at);
            if (cyc == 1) begin
                busy1 = get_busy(which);
                dcs1  = get_dcs(which);
            end
            got = get_done(which);
        end
        set_start(which, 1'b0);
    endtask

    initial begin
        int cyc;
        int nd;
        int done_at;
        logic busy1;
        logic [1:0] dcs1;
        int exp_w [6];
        int exp_x [6];
        exp_w = '{0, 1, 2, 4, 5, 6};
        exp_x = '{0, 1, 2, 0, 1, 2};
        b_dis = '0;
        c_dis = '0;
        mem_a = '{26'd4, 26'd5, 26'd1, 26'd2, 26'd3, 26'd4, 26'd2, 26'd3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_waddr", a_w_addr, 0);
        chk("rst_xaddr", a_x_addr, 0);
        chk("rst_dcvalid", a_dc_valid, 0);
        chk("rst_dcr", a_dc_r, 0);
        chk("rst_dcstate", a_dc_state, 0);
        chk("rst_bmuidx", a_bmu_idx, 0);
        chk("rst_bmudis", a_bmu_dis, ONES);
        chk("rst_ruidx", a_ru_idx, 0);
        chk("rst_rudis", a_ru_dis, ONES);
        rst = 1'b0;
        @(posedge clk); #1;

        // Distances {9,3,7,5}
        run(0, 0, cyc, busy1, dcs1);
        chk("a_latency", cyc, 11);
        chk("a_busy1", busy1, 1);
        chk("a_dcstate1", dcs1, 3);
        chk("a_bmuidx", a_bmu_idx, 1);
        chk("a_bmudis", a_bmu_dis, 3);
`ifdef SOFM_RUNNER_UP_EN
        chk("a_ruidx", a_ru_idx, 3);
        chk("a_rudis", a_ru_dis, 5);
`else
        chk("a_ruidx", a_ru_idx, 0);
        chk("a_rudis", a_ru_dis, ONES);
`endif
        @(posedge clk); #1;
        chk("a_done_pulse", a_done, 0);
        chk("a_busy_after", a_busy, 0);
        chk("a_dcstate_after", a_dc_state, 0);
        chk("a_hold_dis", a_bmu_dis, 3);

        // Tie: distances {4,2,2,8}
        mem_a = '{26'd2, 26'd2, 26'd1, 26'd1, 26'd1, 26'd1, 26'd4, 26'd4};
        run(0, 0, cyc, busy1, dcs1);
        chk("tie_latency", cyc, 11);
        chk("tie_bmuidx", a_bmu_idx, 1);
        chk("tie_bmudis", a_bmu_dis, 2);
`ifdef SOFM_RUNNER_UP_EN
        chk("tie_ruidx", a_ru_idx, 2);
        chk("tie_rudis", a_ru_dis, 2);
`else
        chk("tie_ruidx", a_ru_idx, 0);
        chk("tie_rudis", a_ru_dis, ONES);
`endif
        @(posedge clk); #1;

        // Start pulse while busy must be ignored
        mem_a = '{26'd4, 26'd5, 26'd1, 26'd2, 26'd3, 26'd4, 26'd2, 26'd3};
        run(0, 3, cyc, busy1, dcs1);
        chk("busy_start_latency", cyc, 11);
        chk("busy_start_bmuidx", a_bmu_idx, 1);
        chk("busy_start_bmudis", a_bmu_dis, 3);
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (a_done) nd++;
        end
        chk("busy_start_extra_done", nd, 0);
        chk("busy_start_idle", a_busy, 0);

        // Reset in the middle of ISSUE
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_before", a_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_busy", a_busy, 0);
        chk("mid_dcvalid", a_dc_valid, 0);
        chk("mid_bmudis", a_bmu_dis, ONES);
        chk("mid_waddr", a_w_addr, 0);
        chk("mid_done", a_done, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_done) nd++;
        end
        chk("mid_no_done", nd, 0);
        run(0, 0, cyc, busy1, dcs1);
        chk("mid_rerun_latency", cyc, 11);
        chk("mid_rerun_bmuidx", a_bmu_idx, 1);
        chk("mid_rerun_bmudis", a_bmu_dis, 3);
        @(posedge clk); #1;

        // Issue sequence, N=2 DIM=3
        done_at = 0;
        st_b = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            st_b = 1'b0;
            if (c == 1) chk("b_dcstate", b_dc_state, 3);
            if (c <= 6) begin
                chk($sformatf("b_waddr_c%0d", c), b_w_addr, exp_w[c-1]);
                chk($sformatf("b_xaddr_c%0d", c), b_x_addr, exp_x[c-1]);
            end
            chk($sformatf("b_dcvalid_c%0d", c), b_dc_valid, (c >= 2 && c <= 7));
            chk($sformatf("b_dcr_c%0d", c), b_dc_r, (c == 2 || c == 5));
            if (b_done && done_at == 0) done_at = c;
        end
        chk("b_latency", done_at, 9);

        // N=1, DIM=1, distance 0
        run(2, 0, cyc, busy1, dcs1);
        chk("c_latency", cyc, 4);
        chk("c_bmuidx", c_bmu_idx, 0);
        chk("c_bmudis", c_bmu_dis, 0);
        chk("c_ruidx", c_ru_idx, 0);
        chk("c_rudis", c_ru_dis, ONES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
